rbcp_reg_bank: RTL and testbench

RBCP_REG_BANK -- requirements
Module: rbcp_reg_bank

---
 rtl/rbcp_reg_bank_pkg.sv | 24 ++
 rtl/rbcp_reg_bank_if.sv | 22 ++
 rtl/rbcp_reg_bank_addr_decode.sv | 32 +++
 rtl/rbcp_reg_bank.sv | 103 ++++++++++
 tb/tb_rbcp_reg_bank.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rbcp_reg_bank_pkg.sv
// Shared constants and decode result type for the RBCP register bank.
package rbcp_pkg;

   // Bus geometry
   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 32;

   // Register index width: covers up to 128 control and 128 status registers
   localparam int IDX_W    = 8;
   localparam int MAX_REGS = 128;

   // Offsets of the two register groups relative to BASE_ADDR.
   // Control registers start at the base, status follows the last control.
   localparam int CTRL_OFS = 0;

   // Result of decoding one bus address
   typedef struct packed {
      logic             ctrl_hit;
      logic             stat_hit;
      logic             oor;
      logic [IDX_W-1:0] idx;
   } rbcp_dec_t;

endpackage

// File: rtl/rbcp_reg_bank_if.sv
// RBCP host bus: strobes, address and data towards the bank, ack/read data back.
interface rbcp_if;
   import rbcp_pkg::*;

   logic              rbcp_we;
   logic              rbcp_re;
   logic [ADDR_W-1:0] rbcp_addr;
   logic [DATA_W-1:0] rbcp_wd;
   logic [DATA_W-1:0] rbcp_rd;
   logic              rbcp_ack;

   modport master (
      output rbcp_we, rbcp_re, rbcp_addr, rbcp_wd,
      input  rbcp_rd, rbcp_ack
   );

   modport slave (
      input  rbcp_we, rbcp_re, rbcp_addr, rbcp_wd,
      output rbcp_rd, rbcp_ack
   );

endinterface

// File: rtl/rbcp_reg_bank_addr_decode.sv
// Combinational address decoder: full 32-bit offset from the base, no aliasing.
module rbcp_addr_decode
   import rbcp_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
   parameter int                NUM_CTRL  = 16,
   parameter int                NUM_STAT  = 8
) (
   input  logic [ADDR_W-1:0] i_addr,
   output rbcp_dec_t         o_dec
);

   logic [ADDR_W-1:0] w_offset;

   // Offset wraps modulo 2^32, so addresses below the base land far out of range
   assign w_offset = i_addr - BASE_ADDR;

   // Classify the offset into control / status / out of range and derive the index
   always_comb begin
      o_dec          = '0;
      o_dec.ctrl_hit = (w_offset < ADDR_W'(CTRL_OFS + NUM_CTRL));
      o_dec.stat_hit = (w_offset >= ADDR_W'(CTRL_OFS + NUM_CTRL)) &&
                       (w_offset <  ADDR_W'(CTRL_OFS + NUM_CTRL + NUM_STAT));
      o_dec.oor      = !(o_dec.ctrl_hit || o_dec.stat_hit);
      if (o_dec.ctrl_hit) begin
         o_dec.idx = IDX_W'(w_offset - ADDR_W'(CTRL_OFS));
      end else if (o_dec.stat_hit) begin
         o_dec.idx = IDX_W'(w_offset - ADDR_W'(CTRL_OFS + NUM_CTRL));
      end
   end

endmodule

// File: rtl/rbcp_reg_bank.sv
// RBCP register bank: 8-bit control (optionally self-clearing pulse) and
// read-only status registers behind a one-cycle-latency strobe/ack bus.
module rbcp_reg_bank
   import rbcp_pkg::*;
#(
   parameter logic [ADDR_W-1:0]          BASE_ADDR  = 32'h0000_0000,
   parameter int                         NUM_CTRL   = 16,
   parameter int                         NUM_STAT   = 8,
   parameter logic [NUM_CTRL-1:0]        PULSE_MASK = '0,
   parameter logic [NUM_CTRL*DATA_W-1:0] CTRL_INIT  = '0,
   // Status port keeps one byte when there are no status registers
   localparam int STAT_W = (NUM_STAT > 0) ? NUM_STAT * DATA_W : DATA_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   rbcp_if.slave                        bus,
   output logic [NUM_CTRL*DATA_W-1:0]   ctrl_q,
   output logic [NUM_CTRL-1:0]          ctrl_wr,
   output logic [NUM_CTRL*DATA_W-1:0]   pulse_q,
   input  logic [STAT_W-1:0]            stat_d
);

   rbcp_dec_t         w_dec;
   logic              w_req;
   logic              w_rd_req;
   logic [DATA_W-1:0] w_rd_data;
   logic              r_ack;
   logic [DATA_W-1:0] r_rd;

   rbcp_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .NUM_CTRL  (NUM_CTRL),
      .NUM_STAT  (NUM_STAT)
   ) u_decode (
      .i_addr (bus.rbcp_addr),
      .o_dec  (w_dec)
   );

   // A simultaneous write wins over the read; only one ack is produced
   assign w_req    = bus.rbcp_we | bus.rbcp_re;
   assign w_rd_req = bus.rbcp_re & ~bus.rbcp_we;

   for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
      logic              w_hit;
      logic [DATA_W-1:0] r_ctrl;
      logic [DATA_W-1:0] r_pulse;
      logic              r_wr;

      assign w_hit = bus.rbcp_we & w_dec.ctrl_hit & (w_dec.idx == IDX_W'(gi));

      // Register storage, write strobe and pulse output; pulse registers never hold data
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_ctrl  <= PULSE_MASK[gi] ? '0 : CTRL_INIT[gi*DATA_W +: DATA_W];
            r_pulse <= '0;
            r_wr    <= 1'b0;
         end else begin
            r_wr    <= w_hit;
            r_pulse <= (w_hit && PULSE_MASK[gi]) ? bus.rbcp_wd : '0;
            if (w_hit && !PULSE_MASK[gi]) begin
               r_ctrl <= bus.rbcp_wd;
            end
         end
      end

      assign ctrl_q [gi*DATA_W +: DATA_W] = r_ctrl;
      assign pulse_q[gi*DATA_W +: DATA_W] = r_pulse;
      assign ctrl_wr[gi]                  = r_wr;
   end

   // Select the addressed byte; status comes straight from stat_d at the capturing edge
   always_comb begin
      w_rd_data = '0;
      if (w_dec.ctrl_hit) begin
         for (int i = 0; i < NUM_CTRL; i++) begin
            if (w_dec.idx == IDX_W'(i)) begin
               w_rd_data = ctrl_q[i*DATA_W +: DATA_W];
            end
         end
      end else if (w_dec.stat_hit) begin
         for (int j = 0; j < NUM_STAT; j++) begin
            if (w_dec.idx == IDX_W'(j)) begin
               w_rd_data = stat_d[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Ack every in-range request one cycle later; read data is zero unless a read is acked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack <= 1'b0;
         r_rd  <= '0;
      end else begin
         r_ack <= w_req & ~w_dec.oor;
         r_rd  <= (w_rd_req && !w_dec.oor) ? w_rd_data : '0;
      end
   end

   assign bus.rbcp_ack = r_ack;
   assign bus.rbcp_rd  = r_rd;

endmodule

// File: tb/tb_rbcp_reg_bank.sv
// Directed testbench for rbcp_reg_bank with hand-computed expected values.
module tb_rbcp_reg_bank;

   localparam logic [31:0]  BASE = 32'h8000_0010;
   localparam int           NC   = 16;
   localparam int           NS   = 8;
   localparam logic [15:0]  PM   = 16'h0004;
   // byte0=00 byte1=11 byte2=FF (pulse reg, must reset to 0) byte3=A5
   localparam logic [127:0] INIT = {96'h0, 8'hA5, 8'hFF, 8'h11, 8'h00};

   logic         clk;
   logic         rst_n;
   logic [127:0] ctrl_q;
   logic [15:0]  ctrl_wr;
   logic [127:0] pulse_q;
   logic [63:0]  stat_d;

   int n_checks;
   int n_fail;

   rbcp_if bus ();

   rbcp_reg_bank #(
      .BASE_ADDR  (BASE),
      .NUM_CTRL   (NC),
      .NUM_STAT   (NS),
      .PULSE_MASK (PM),
      .CTRL_INIT  (INIT)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .ctrl_q  (ctrl_q),
      .ctrl_wr (ctrl_wr),
      .pulse_q (pulse_q),
      .stat_d  (stat_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one bus cycle at the falling edge, return 1 time unit after the next rising edge
   task automatic step(input logic we, input logic re, input logic [31:0] addr, input logic [7:0] wd);
      @(negedge clk);
      bus.rbcp_we   = we;
      bus.rbcp_re   = re;
      bus.rbcp_addr = addr;
      bus.rbcp_wd   = wd;
      @(posedge clk);
      #1;
      $display("txn we=%0b re=%0b addr=%h wd=%h -> ack=%0b rd=%h", we, re, addr, wd,
               bus.rbcp_ack, bus.rbcp_rd);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 8'h00);
   endtask

   // Issue a request and count acks over the following 8 cycles
   task automatic no_ack(input string tag, input logic we, input logic re, input logic [31:0] addr);
      int acks;
      acks = 0;
      step(we, re, addr, 8'hEE);
      if (bus.rbcp_ack) acks++;
      for (int k = 0; k < 7; k++) begin
         idle();
         if (bus.rbcp_ack) acks++;
      end
      check(tag, 128'(acks), 128'd0);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      stat_d        = 64'h0;
      bus.rbcp_we   = 1'b0;
      bus.rbcp_re   = 1'b0;
      bus.rbcp_addr = 32'h0;
      bus.rbcp_wd   = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack",     128'(bus.rbcp_ack), 128'd0);
      check("rst_rd",      128'(bus.rbcp_rd),  128'd0);
      check("rst_ctrl_wr", 128'(ctrl_wr),      128'd0);
      check("rst_pulse",   pulse_q,            128'd0);
      check("rst_ctrl_q",  ctrl_q,             128'hA500_1100);

      // First request in the first cycle after release: read init byte 3
      @(negedge clk);
      rst_n         = 1'b1;
      bus.rbcp_re   = 1'b1;
      bus.rbcp_addr = BASE + 32'd3;
      @(posedge clk);
      #1;
      $display("txn we=0 re=1 addr=%h -> ack=%0b rd=%h", BASE + 32'd3, bus.rbcp_ack, bus.rbcp_rd);
      check("rd3_ack", 128'(bus.rbcp_ack), 128'd1);
      check("rd3_data", 128'(bus.rbcp_rd), 128'hA5);
      idle();
      check("rd3_ack_drop", 128'(bus.rbcp_ack), 128'd0);
      check("rd3_rd_zero",  128'(bus.rbcp_rd),  128'd0);

      // Write 3C to register 5
      step(1'b1, 1'b0, BASE + 32'd5, 8'h3C);
      check("wr5_ack",     128'(bus.rbcp_ack), 128'd1);
      check("wr5_rd",      128'(bus.rbcp_rd),  128'd0);
      check("wr5_ctrl_wr", 128'(ctrl_wr),      128'h0020);
      check("wr5_q",       128'(ctrl_q[47:40]), 128'h3C);
      idle();
      check("wr5_ctrl_wr_drop", 128'(ctrl_wr),      128'd0);
      check("wr5_ack_drop",     128'(bus.rbcp_ack), 128'd0);
      step(1'b0, 1'b1, BASE + 32'd5, 8'h00);
      check("rb5", 128'(bus.rbcp_rd), 128'h3C);

      // Pulse register 2
      step(1'b1, 1'b0, BASE + 32'd2, 8'h81);
      check("pls_q",    pulse_q,        128'h0081_0000);
      check("pls_wr",   128'(ctrl_wr),  128'h0004);
      idle();
      check("pls_drop", pulse_q,        128'd0);
      check("pls_ctrl", 128'(ctrl_q[23:16]), 128'h00);
      step(1'b0, 1'b1, BASE + 32'd2, 8'h00);
      check("pls_ack", 128'(bus.rbcp_ack), 128'd1);
      check("pls_rb",  128'(bus.rbcp_rd),  128'h00);

      // Status registers
      stat_d = 64'h0000_0000_0000_427E;
      step(1'b0, 1'b1, BASE + 32'd16, 8'h00);
      check("st0_ack", 128'(bus.rbcp_ack), 128'd1);
      check("st0_rd",  128'(bus.rbcp_rd),  128'h7E);
      step(1'b0, 1'b1, BASE + 32'd17, 8'h00);
      check("st1_rd",  128'(bus.rbcp_rd),  128'h42);
      step(1'b1, 1'b0, BASE + 32'd16, 8'hAA);
      check("stw_ack", 128'(bus.rbcp_ack), 128'd1);
      check("stw_wr",  128'(ctrl_wr),      128'd0);
      check("stw_q",   ctrl_q,             128'hA500_1100 | (128'h3C << 40));
      step(1'b0, 1'b1, BASE + 32'd16, 8'h00);
      check("stw_rb",  128'(bus.rbcp_rd),  128'h7E);

      // Out-of-range addresses: no ack, no state change
      no_ack("oor_end",   1'b0, 1'b1, BASE + 32'd24);
      no_ack("oor_below", 1'b0, 1'b1, BASE - 32'd1);
      no_ack("oor_alias", 1'b0, 1'b1, BASE + 32'h103);
      no_ack("oor_wr",    1'b1, 1'b0, BASE + 32'd24);
      check("oor_q", ctrl_q, 128'hA500_1100 | (128'h3C << 40));

      // Back-to-back strobes
      step(1'b1, 1'b0, BASE + 32'd6, 8'h01);
      check("b2b_ack0", 128'(bus.rbcp_ack), 128'd1);
      check("b2b_wr0",  128'(ctrl_wr),      128'h0040);
      step(1'b1, 1'b0, BASE + 32'd7, 8'h02);
      check("b2b_ack1", 128'(bus.rbcp_ack), 128'd1);
      check("b2b_wr1",  128'(ctrl_wr),      128'h0080);
      step(1'b0, 1'b1, BASE + 32'd6, 8'h00);
      check("b2b_ack2", 128'(bus.rbcp_ack), 128'd1);
      check("b2b_rd2",  128'(bus.rbcp_rd),  128'h01);
      step(1'b0, 1'b1, BASE + 32'd7, 8'h00);
      check("b2b_ack3", 128'(bus.rbcp_ack), 128'd1);
      check("b2b_rd3",  128'(bus.rbcp_rd),  128'h02);
      idle();
      check("b2b_end",  128'(bus.rbcp_ack), 128'd0);

      // Write and read together: write wins, single ack
      step(1'b1, 1'b1, BASE + 32'd4, 8'h99);
      check("wr_rd_ack", 128'(bus.rbcp_ack), 128'd1);
      check("wr_rd_rd",  128'(bus.rbcp_rd),  128'd0);
      check("wr_rd_q",   128'(ctrl_q[39:32]), 128'h99);
      idle();
      check("wr_rd_single", 128'(bus.rbcp_ack), 128'd0);

      // Reset during the ack cycle cancels it and restores init values
      step(1'b1, 1'b1, BASE + 32'd1, 8'h55);
      check("rst_pre_ack", 128'(bus.rbcp_ack), 128'd1);
      check("rst_pre_q",   128'(ctrl_q[15:8]), 128'h55);
      rst_n = 1'b0;
      #1;
      check("rst_cancel_ack", 128'(bus.rbcp_ack), 128'd0);
      check("rst_cancel_q1",  128'(ctrl_q[15:8]), 128'h11);
      check("rst_cancel_wr",  128'(ctrl_wr),      128'd0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      check("post_rst_ack", 128'(bus.rbcp_ack), 128'd0);
      step(1'b0, 1'b1, BASE + 32'd1, 8'h00);
      check("post_rst_rd1", 128'(bus.rbcp_rd), 128'h11);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
